// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller.
// Cycles through NDIG digits: each one is lit for DIV clocks and then followed by a
// BLANK-clock all-off gap. One hex decoder is shared by all digits.
// A new display word waits in a pending buffer and becomes active only at a frame
// boundary, so a frame never mixes old and new digits.
module seg_scan_ctrl #(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [4*NDIG-1:0] ld_data,
  input  logic [NDIG-1:0]   ld_mask,
  input  logic              lz_en,
  output logic [NDIG-1:0]   dig_sel,
  output logic [3:0]        dig_nib,
  output logic              dig_blank,
  output logic              frame_done
);

  localparam int IDX_W = $clog2(NDIG);
  localparam int CMAX  = (DIV > BLANK) ? DIV : BLANK;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_fd, w_fd_nxt;
  logic              w_commit, w_adv, w_hs;

  logic              r_pend;
  logic [4*NDIG-1:0] r_pend_data;
  logic [NDIG-1:0]   r_pend_mask;
  logic              r_pend_lz;

  logic [4*NDIG-1:0] r_act_data;
  logic [NDIG-1:0]   r_act_mask;
  logic              r_act_lz;

  logic [NDIG-1:0]   w_supp;
  logic [3:0]        w_nib;

  // A load is accepted only while nothing is waiting in the pending buffer.
  // Commit needs a full buffer, so a handshake and a commit never fall on the same edge.
  assign w_hs     = ld_valid & ~r_pend;
  assign ld_ready = ~r_pend;

  // Leading-zero suppression: walk from the top nibble down while every nibble seen is zero
  always_comb begin
    logic allz;
    w_supp = '0;
    allz   = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      allz = allz & (r_act_data[4*i +: 4] == 4'h0);
      if (i != 0) w_supp[i] = r_act_lz & allz;
    end
  end

  assign w_nib = r_act_data[4*r_idx +: 4];

  // Scan sequencer: next state, digit index, dwell counter, commit and frame-end pulse
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    w_fd_nxt    = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_commit    = 1'b1;
          w_state_nxt = S_ON;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_ON: begin
        if (r_cnt == ON_LAST) begin
          w_cnt_nxt = '0;
          if (BLANK == 0) w_adv = 1'b1;
          else            w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          w_adv     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_adv) begin
      if (r_idx != IDX_LAST) begin
        w_idx_nxt   = r_idx + IDX_W'(1);
        w_state_nxt = S_ON;
      end else begin
        // Frame boundary: the only point where a new word may take over.
        w_fd_nxt  = 1'b1;
        w_idx_nxt = '0;
        w_commit  = r_pend;
        if ((r_pend ? r_pend_mask : r_act_mask) == '0) w_state_nxt = S_IDLE;
        else                                            w_state_nxt = S_ON;
      end
    end
  end

  // Sequencer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  // Pending buffer: filled by the load handshake, emptied by the commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_pend_mask <= '0;
      r_pend_lz   <= 1'b0;
    end else if (w_commit) begin
      r_pend <= 1'b0;
    end else if (w_hs) begin
      r_pend      <= 1'b1;
      r_pend_data <= ld_data;
      r_pend_mask <= ld_mask;
      r_pend_lz   <= lz_en;
    end
  end

  // Active word: replaced only on commit, so it stays fixed for a whole frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_data <= '0;
      r_act_mask <= '0;
      r_act_lz   <= 1'b0;
    end else if (w_commit) begin
      r_act_data <= r_pend_data;
      r_act_mask <= r_pend_mask;
      r_act_lz   <= r_pend_lz;
    end
  end

  // Outputs decode directly from registered state; GAP and IDLE drive every digit line high.
  assign dig_sel    = (r_state == S_ON) ? ~(NDIG'(1) << r_idx) : '1;
  assign dig_nib    = (r_state == S_IDLE) ? 4'h0 : w_nib;
  assign dig_blank  = (r_state == S_ON) ? (~r_act_mask[r_idx] | w_supp[r_idx]) : 1'b1;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: NDIG=4, DIV=4, with BLANK=2 (dut) and BLANK=0 (dut0).
// Each expected output cycle is pushed to a queue when its stimulus is applied, and
// then popped and compared on the falling edge while the DUT shows that cycle.
module tb_seg_scan_ctrl;
  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 2;
  localparam logic [9:0] IDLE_E  = {4'hF, 4'h0, 1'b1, 1'b0};
  localparam logic [9:0] IDLE_FD = {4'hF, 4'h0, 1'b1, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = '0;
  logic [3:0]  ld_mask = '0;
  logic        lz_en = 1'b0;
  logic        ld_ready, dig_blank, frame_done;
  logic [3:0]  dig_sel, dig_nib;
  logic        ld_ready0, dig_blank0, frame_done0;
  logic [3:0]  dig_sel0, dig_nib0;

  logic [9:0]  q[$];
  logic [9:0]  e;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_mask(ld_mask), .lz_en(lz_en),
    .dig_sel(dig_sel), .dig_nib(dig_nib), .dig_blank(dig_blank), .frame_done(frame_done)
  );

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(0)) dut0 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready0),
    .ld_data(ld_data), .ld_mask(ld_mask), .lz_en(lz_en),
    .dig_sel(dig_sel0), .dig_nib(dig_nib0), .dig_blank(dig_blank0), .frame_done(frame_done0)
  );

  // Push the expected output of one whole frame: each digit lit for DIV cycles, then blank cycles of gap.
  function automatic void push_frame(input logic [15:0] d, input logic [3:0] m,
                                     input logic lz, input logic fd, input int blank);
    int h;
    logic [3:0] nb;
    logic bl;
    h = -1;
    for (int i = 0; i < 4; i++) if (d[4*i +: 4] != 4'h0) h = i;
    for (int i = 0; i < 4; i++) begin
      nb = d[4*i +: 4];
      bl = !m[i] || (lz && i >= 1 && i > h);
      for (int k = 0; k < DIV; k++)
        q.push_back({~(4'b0001 << i), nb, bl, (fd && i == 0 && k == 0)});
      for (int k = 0; k < blank; k++)
        q.push_back({4'hF, nb, 1'b1, 1'b0});
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ld_valid = 1'b0;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++; if (dig_sel !== 4'hF) begin bad++; $display("FAIL reset_sel got=%h exp=f", dig_sel); end
    total++; if (dig_nib !== 4'h0) begin bad++; $display("FAIL reset_nib got=%h exp=0", dig_nib); end
    total++; if (dig_blank !== 1'b1) begin bad++; $display("FAIL reset_blank got=%b exp=1", dig_blank); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ld_ready); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    @(negedge clk);
    rst = 1'b0;
    ld_data = 16'h00A5; ld_mask = 4'hF; lz_en = 1'b1; ld_valid = 1'b1;
    q.delete();
    q.push_back(IDLE_E);
    push_frame(16'h00A5, 4'hF, 1'b1, 1'b0, BLANK);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      e = q.pop_front(); total++;
      if ({dig_sel, dig_nib, dig_blank, frame_done} !== e) begin
        bad++; $display("FAIL reset_scan c=%0d got=%h exp=%h", c, {dig_sel, dig_nib, dig_blank, frame_done}, e);
      end
      if (c == 1) ld_valid = 1'b0;
      if (c == 9) begin ld_data = 16'h1234; ld_valid = 1'b1; end
    end
    @(negedge clk);
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_pend_ready got=%b exp=0", ld_ready); end
    ld_valid = 1'b0;
    @(posedge clk);
    #2;
    total++; if (dig_sel !== 4'b1101) begin bad++; $display("FAIL reset_preon got=%h exp=d", dig_sel); end
    rst = 1'b1;
    #1;
    total++; if (dig_sel !== 4'hF) begin bad++; $display("FAIL midreset_sel got=%h exp=f", dig_sel); end
    total++; if (dig_nib !== 4'h0) begin bad++; $display("FAIL midreset_nib got=%h exp=0", dig_nib); end
    total++; if (dig_blank !== 1'b1) begin bad++; $display("FAIL midreset_blank got=%b exp=1", dig_blank); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b exp=1", ld_ready); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL midreset_fd got=%b exp=0", frame_done); end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if ({dig_sel, ld_ready} !== {4'hF, 1'b1}) begin
        bad++; $display("FAIL reset_discard c=%0d got=%h exp=%h", c, {dig_sel, ld_ready}, {4'hF, 1'b1});
      end
    end
  endtask

  task automatic test_lz();
    int n;
    do_reset();
    ld_data = 16'h00A5; ld_mask = 4'hF; lz_en = 1'b1; ld_valid = 1'b1;
    q.push_back(IDLE_E);
    push_frame(16'h00A5, 4'hF, 1'b1, 1'b0, BLANK);
    push_frame(16'h00A5, 4'hF, 1'b1, 1'b1, BLANK);
    push_frame(16'h00A5, 4'hF, 1'b1, 1'b1, BLANK);
    n = q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = q.pop_front(); total++;
      if ({dig_sel, dig_nib, dig_blank, frame_done} !== e) begin
        bad++; $display("FAIL lz_scan c=%0d got=%h exp=%h", c, {dig_sel, dig_nib, dig_blank, frame_done}, e);
      end
      if (c == 1) ld_valid = 1'b0;
    end
  endtask

  task automatic test_nolz();
    int n;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      ld_data = (t == 0) ? 16'h00A5 : 16'h0000;
      lz_en = (t == 0) ? 1'b0 : 1'b1;
      ld_mask = 4'hF; ld_valid = 1'b1;
      q.push_back(IDLE_E);
      push_frame(ld_data, 4'hF, lz_en, 1'b0, BLANK);
      n = q.size();
      for (int c = 1; c <= n; c++) begin
        @(negedge clk);
        e = q.pop_front(); total++;
        if ({dig_sel, dig_nib, dig_blank, frame_done} !== e) begin
          bad++; $display("FAIL nolz_scan t=%0d c=%0d got=%h exp=%h", t, c, {dig_sel, dig_nib, dig_blank, frame_done}, e);
        end
        if (c == 1) ld_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    do_reset();
    ld_data = 16'h00A5; ld_mask = 4'hF; lz_en = 1'b1; ld_valid = 1'b1;
    q.push_back(IDLE_E);
    push_frame(16'h00A5, 4'hF, 1'b1, 1'b0, BLANK);
    push_frame(16'h1234, 4'hF, 1'b0, 1'b1, BLANK);
    push_frame(16'hBEEF, 4'hF, 1'b0, 1'b1, BLANK);
    for (int c = 1; c <= 73; c++) begin
      @(negedge clk);
      e = q.pop_front(); total++;
      if ({dig_sel, dig_nib, dig_blank, frame_done} !== e) begin
        bad++; $display("FAIL b2b_scan c=%0d got=%h exp=%h", c, {dig_sel, dig_nib, dig_blank, frame_done}, e);
      end
      exp_rdy = !((c == 1) || (c >= 9 && c <= 25) || (c >= 27 && c <= 49));
      total++;
      if (ld_ready !== exp_rdy) begin
        bad++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, ld_ready, exp_rdy);
      end
      if (c == 1) ld_valid = 1'b0;
      if (c == 8) begin ld_data = 16'h1234; lz_en = 1'b0; ld_valid = 1'b1; end
      if (c == 9) ld_data = 16'hBEEF;
      if (c == 27) ld_valid = 1'b0;
    end
  endtask

  task automatic test_mask_off();
    int n;
    do_reset();
    ld_data = 16'h00A5; ld_mask = 4'hF; lz_en = 1'b1; ld_valid = 1'b1;
    q.push_back(IDLE_E);
    push_frame(16'h00A5, 4'hF, 1'b1, 1'b0, BLANK);
    q.push_back(IDLE_FD);
    for (int k = 0; k < 10; k++) q.push_back(IDLE_E);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      e = q.pop_front(); total++;
      if ({dig_sel, dig_nib, dig_blank, frame_done} !== e) begin
        bad++; $display("FAIL mask0_scan c=%0d got=%h exp=%h", c, {dig_sel, dig_nib, dig_blank, frame_done}, e);
      end
      if (c == 1) ld_valid = 1'b0;
      if (c == 5) begin ld_data = 16'h5678; ld_mask = 4'h0; lz_en = 1'b0; ld_valid = 1'b1; end
      if (c == 6) ld_valid = 1'b0;
    end
    ld_data = 16'h4200; ld_mask = 4'b0011; lz_en = 1'b1; ld_valid = 1'b1;
    q.push_back(IDLE_E);
    push_frame(16'h4200, 4'b0011, 1'b1, 1'b0, BLANK);
    n = q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = q.pop_front(); total++;
      if ({dig_sel, dig_nib, dig_blank, frame_done} !== e) begin
        bad++; $display("FAIL mask_reload c=%0d got=%h exp=%h", c, {dig_sel, dig_nib, dig_blank, frame_done}, e);
      end
      if (c == 1) ld_valid = 1'b0;
    end
  endtask

  task automatic test_no_blank();
    int n;
    do_reset();
    total++; if (ld_ready0 !== 1'b1) begin bad++; $display("FAIL nb_ready got=%b exp=1", ld_ready0); end
    ld_data = 16'h00A5; ld_mask = 4'hF; lz_en = 1'b0; ld_valid = 1'b1;
    q.push_back(IDLE_E);
    push_frame(16'h00A5, 4'hF, 1'b0, 1'b0, 0);
    push_frame(16'h00A5, 4'hF, 1'b0, 1'b1, 0);
    n = q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = q.pop_front(); total++;
      if ({dig_sel0, dig_nib0, dig_blank0, frame_done0} !== e) begin
        bad++; $display("FAIL nb_scan c=%0d got=%h exp=%h", c, {dig_sel0, dig_nib0, dig_blank0, frame_done0}, e);
      end
      if (c == 1) ld_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_lz();
    test_nolz();
    test_back_to_back();
    test_mask_off();
    test_no_blank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
